// File: rtl/regfile_dump_reader.sv
// Debug reader: walks a register index range on one regfile read port and streams
// (index, data) beats over valid/ready, then pulses done (with err on an empty range).
module regfile_dump_reader #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] first_idx,
  input  logic [AW-1:0] last_idx,
  input  logic          abort,
  output logic [AW-1:0] ra,
  input  logic [DW-1:0] rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_HOLD,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] r_last;
  logic          r_err;
  logic          r_valid;
  logic [AW-1:0] r_out_idx;
  logic [DW-1:0] r_out_data;
  logic          w_port_owned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_last     <= '0;
      r_err      <= 1'b0;
      r_valid    <= 1'b0;
      r_out_idx  <= '0;
      r_out_data <= '0;
    end else if (abort && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // abort outranks start even while idle
          if (start && !abort) begin
            r_idx  <= first_idx;
            r_last <= last_idx;
            if (first_idx <= last_idx) begin
              r_state <= S_READ;
              r_err   <= 1'b0;
            end else begin
              r_state <= S_DONE;
              r_err   <= 1'b1;
            end
          end
        end
        S_READ: begin
          r_out_data <= rd;
          r_out_idx  <= r_idx;
          r_valid    <= 1'b1;
          r_state    <= S_HOLD;
        end
        S_HOLD: begin
          if (r_valid && out_ready) begin
            r_valid <= 1'b0;
            // compare before increment so a range ending at the top index never wraps
            if (r_idx == r_last) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_READ;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_port_owned = (r_state == S_READ) || (r_state == S_HOLD);
  assign ra           = w_port_owned ? r_idx : '0;
  assign out_valid    = r_valid;
  assign out_idx      = r_out_idx;
  assign out_data     = r_out_data;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign err          = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: behavioural regfile, consumer with
// optional stalls, abort, ignored restart and asynchronous reset cases.
module tb_regfile_dump_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  first_idx;
  logic [4:0]  last_idx;
  logic        abort;
  logic [4:0]  ra;
  logic [31:0] rd;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic        err;

  logic [31:0] rf [32];
  int          n_checks;
  int          n_errors;

  regfile_dump_reader #(.DW(32), .AW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .first_idx (first_idx),
    .last_idx  (last_idx),
    .abort     (abort),
    .ra        (ra),
    .rd        (rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  assign rd = (ra == 5'd0) ? 32'd0 : rf[ra];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_dump(input string tag, input logic [4:0] f, input logic [4:0] l,
                          input int stall, input int exp_beats, input int exp_err,
                          input bit poke);
    int          beats, dones, errs, stall_cnt, first_v, done_c;
    logic [4:0]  exp_idx, h_idx;
    logic [31:0] h_data, exp_data;
    bit          have, fin;
    beats = 0; dones = 0; errs = 0; stall_cnt = 0; first_v = -1; done_c = -1;
    exp_idx = f; have = 0; fin = 0; h_idx = '0; h_data = '0;
    @(negedge clk);
    start = 1; first_idx = f; last_idx = l; out_ready = (stall == 0);
    for (int c = 1; c < 300 && !fin; c++) begin
      @(negedge clk);
      start = 0;
      if (poke && beats == 1 && out_valid) begin
        start = 1; first_idx = 5'd0; last_idx = 5'd0;
      end
      if (done) begin
        dones++; done_c = c; fin = 1;
        if (err) errs++;
        check({tag, "_busy_in_done"}, busy, 1);
      end
      if (out_valid) begin
        if (first_v < 0) begin
          first_v = c;
          check({tag, "_busy_first"}, busy, 1);
        end
        if (have) begin
          check({tag, "_stall_idx"}, out_idx, h_idx);
          check({tag, "_stall_data"}, out_data, h_data);
        end else begin
          have = 1; h_idx = out_idx; h_data = out_data; stall_cnt = 0;
        end
        if (stall_cnt < stall) begin
          out_ready = 0; stall_cnt++;
        end else begin
          out_ready = 1;
          exp_data = 32'(exp_idx) * 32'h11111111;
          check({tag, "_idx"}, out_idx, exp_idx);
          check({tag, "_data"}, out_data, exp_data);
          beats++; exp_idx++; have = 0;
        end
      end
    end
    out_ready = 0; start = 0;
    check({tag, "_beats"}, beats, exp_beats);
    check({tag, "_dones"}, dones, 1);
    check({tag, "_err"}, errs, exp_err);
    if (exp_beats > 0) check({tag, "_latency"}, first_v, 2);
    else check({tag, "_done_latency"}, done_c, 1);
    @(negedge clk);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_ra_idle"}, ra, 0);
  endtask

  initial begin
    bit found;
    n_checks = 0; n_errors = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h11111111;
    rst_n = 0; start = 0; first_idx = '0; last_idx = '0; abort = 0; out_ready = 0;
    #12;
    check("rst_ra", ra, 0);
    check("rst_valid", out_valid, 0);
    check("rst_idx", out_idx, 0);
    check("rst_data", out_data, 0);
    check("rst_flags", {busy, done, err}, 0);
    @(negedge clk); rst_n = 1;

    run_dump("full", 5'd0, 5'd31, 0, 32, 0, 0);
    run_dump("stall", 5'd5, 5'd7, 3, 3, 0, 0);
    run_dump("empty", 5'd9, 5'd4, 0, 0, 1, 0);

    // abort while holding the beat for index 29
    @(negedge clk);
    start = 1; first_idx = 5'd28; last_idx = 5'd31; out_ready = 1; found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      start = 0;
      if (out_valid && out_idx == 5'd29) begin
        found = 1; out_ready = 0; abort = 1;
      end
    end
    check("abort_reach", found, 1);
    @(negedge clk);
    abort = 0;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_no_done", {done, err, out_valid}, 0);
    end
    run_dump("single", 5'd3, 5'd3, 0, 1, 0, 0);

    run_dump("restart", 5'd10, 5'd12, 0, 3, 0, 1);

    // abort and start together in IDLE
    @(negedge clk);
    start = 1; abort = 1; first_idx = 5'd2; last_idx = 5'd4;
    @(negedge clk);
    start = 0; abort = 0;
    check("abort_start_busy", busy, 0);
    @(negedge clk);
    check("abort_start_valid", out_valid, 0);

    // asynchronous reset while holding a beat
    @(negedge clk);
    start = 1; first_idx = 5'd3; last_idx = 5'd4; out_ready = 0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    check("prerst_valid", out_valid, 1);
    check("prerst_idx", out_idx, 3);
    check("prerst_ra", ra, 3);
    #2 rst_n = 0;
    #1;
    check("arst_ra", ra, 0);
    check("arst_valid", out_valid, 0);
    check("arst_idx", out_idx, 0);
    check("arst_data", out_data, 0);
    check("arst_flags", {busy, done, err}, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
